// File: rtl/mem_ram_seq.sv
// Strobe sequencer for the three local DRAM banks: single-word accesses with
// row/column multiplexing on AA_9_0, plus periodic CBR refresh arbitrated against requests.
module mem_ram_seq #(
  parameter int T_RCD        = 2,
  parameter int T_CAS        = 2,
  parameter int T_RP         = 2,
  parameter int T_REF        = 3,
  parameter int REF_INTERVAL = 1000
) (
  input  logic        sysclk,
  input  logic        sys_rst_n,
  input  logic        MREQ,
  input  logic        MWR,
  input  logic [21:0] MADDR,
  output logic        MACK,
  output logic        MERR,
  output logic        BUSY,
  output logic [9:0]  AA_9_0,
  output logic        RAS,
  output logic        CAS,
  output logic        BANK0,
  output logic        BANK1,
  output logic        BANK2,
  output logic        MWRITE50_n,
  output logic        REF_LATE
);

  localparam int CW = $clog2(REF_INTERVAL);
  localparam int WW = 16;
  localparam logic [CW-1:0] REF_RELOAD = CW'(REF_INTERVAL - 1);

  typedef enum logic [3:0] {
    IDLE, ROW, RAS_W, COL, CAS_W, PRE, RROW, RREF, ERR
  } state_t;

  state_t          state_r;
  logic [WW-1:0]   wcnt_r;
  logic [1:0]      bank_r;
  logic [9:0]      row_r;
  logic [9:0]      col_r;
  logic            wr_r;
  logic [CW-1:0]   ref_cnt_r;
  logic            ref_pending_r;
  logic            ref_expire_s;
  logic            ref_take_s;

  function automatic logic [2:0] bank_onehot(input logic [1:0] b);
    logic [2:0] oh;
    case (b)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  assign ref_expire_s = (ref_cnt_r == {CW{1'b0}});
  assign ref_take_s   = (state_r == IDLE) && ref_pending_r;

  // Refresh interval counter, pending request and sticky overrun flag.
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ref_cnt_r     <= REF_RELOAD;
      ref_pending_r <= 1'b0;
      REF_LATE      <= 1'b0;
    end else begin
      if (ref_expire_s) begin
        ref_cnt_r     <= REF_RELOAD;
        ref_pending_r <= 1'b1;
        // An expiry landing on the RROW entry simply re-arms the request.
        if (ref_pending_r && !ref_take_s) begin
          REF_LATE <= 1'b1;
        end
      end else begin
        ref_cnt_r <= ref_cnt_r - CW'(1);
        if (ref_take_s) begin
          ref_pending_r <= 1'b0;
        end
      end
    end
  end

  // Access/refresh FSM; outputs are registered from the current state.
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r    <= IDLE;
      wcnt_r     <= {WW{1'b0}};
      bank_r     <= 2'd0;
      row_r      <= 10'd0;
      col_r      <= 10'd0;
      wr_r       <= 1'b0;
      MACK       <= 1'b0;
      MERR       <= 1'b0;
      BUSY       <= 1'b0;
      AA_9_0     <= 10'd0;
      RAS        <= 1'b0;
      CAS        <= 1'b0;
      BANK0      <= 1'b0;
      BANK1      <= 1'b0;
      BANK2      <= 1'b0;
      MWRITE50_n <= 1'b1;
    end else begin
      MACK <= 1'b0;
      MERR <= 1'b0;
      case (state_r)
        IDLE: begin
          BUSY                <= 1'b0;
          RAS                 <= 1'b0;
          CAS                 <= 1'b0;
          {BANK2,BANK1,BANK0} <= 3'b000;
          MWRITE50_n          <= 1'b1;
          if (ref_pending_r) begin
            state_r <= RROW;
          end else if (MREQ) begin
            bank_r  <= MADDR[21:20];
            row_r   <= MADDR[19:10];
            col_r   <= MADDR[9:0];
            wr_r    <= MWR;
            state_r <= (MADDR[21:20] == 2'd3) ? ERR : ROW;
          end else begin
            state_r <= IDLE;
          end
        end
        ROW: begin
          BUSY                <= 1'b1;
          AA_9_0              <= row_r;
          {BANK2,BANK1,BANK0} <= bank_onehot(bank_r);
          RAS                 <= 1'b0;
          CAS                 <= 1'b0;
          MWRITE50_n          <= 1'b1;
          wcnt_r              <= WW'(T_RCD - 1);
          state_r             <= RAS_W;
        end
        RAS_W: begin
          BUSY                <= 1'b1;
          AA_9_0              <= row_r;
          {BANK2,BANK1,BANK0} <= bank_onehot(bank_r);
          RAS                 <= 1'b1;
          CAS                 <= 1'b0;
          MWRITE50_n          <= 1'b1;
          if (wcnt_r == {WW{1'b0}}) begin
            state_r <= COL;
          end else begin
            wcnt_r <= wcnt_r - WW'(1);
          end
        end
        COL: begin
          BUSY                <= 1'b1;
          AA_9_0              <= col_r;
          {BANK2,BANK1,BANK0} <= bank_onehot(bank_r);
          RAS                 <= 1'b1;
          CAS                 <= 1'b0;
          MWRITE50_n          <= ~wr_r;
          wcnt_r              <= WW'(T_CAS - 1);
          state_r             <= CAS_W;
        end
        CAS_W: begin
          BUSY                <= 1'b1;
          AA_9_0              <= col_r;
          {BANK2,BANK1,BANK0} <= bank_onehot(bank_r);
          RAS                 <= 1'b1;
          CAS                 <= 1'b1;
          MWRITE50_n          <= ~wr_r;
          if (wcnt_r == {WW{1'b0}}) begin
            MACK    <= 1'b1;
            wcnt_r  <= WW'(T_RP - 1);
            state_r <= PRE;
          end else begin
            wcnt_r <= wcnt_r - WW'(1);
          end
        end
        PRE: begin
          BUSY                <= 1'b1;
          RAS                 <= 1'b0;
          CAS                 <= 1'b0;
          {BANK2,BANK1,BANK0} <= 3'b000;
          MWRITE50_n          <= 1'b1;
          if (wcnt_r == {WW{1'b0}}) begin
            state_r <= IDLE;
          end else begin
            wcnt_r <= wcnt_r - WW'(1);
          end
        end
        RROW: begin
          BUSY                <= 1'b1;
          RAS                 <= 1'b0;
          CAS                 <= 1'b1;
          {BANK2,BANK1,BANK0} <= 3'b111;
          MWRITE50_n          <= 1'b1;
          wcnt_r              <= WW'(T_REF - 1);
          state_r             <= RREF;
        end
        RREF: begin
          BUSY                <= 1'b1;
          RAS                 <= 1'b1;
          CAS                 <= 1'b1;
          {BANK2,BANK1,BANK0} <= 3'b111;
          MWRITE50_n          <= 1'b1;
          if (wcnt_r == {WW{1'b0}}) begin
            wcnt_r  <= WW'(T_RP - 1);
            state_r <= PRE;
          end else begin
            wcnt_r <= wcnt_r - WW'(1);
          end
        end
        ERR: begin
          BUSY                <= 1'b1;
          MACK                <= 1'b1;
          MERR                <= 1'b1;
          RAS                 <= 1'b0;
          CAS                 <= 1'b0;
          {BANK2,BANK1,BANK0} <= 3'b000;
          MWRITE50_n          <= 1'b1;
          state_r             <= IDLE;
        end
        default: begin
          BUSY                <= 1'b0;
          RAS                 <= 1'b0;
          CAS                 <= 1'b0;
          {BANK2,BANK1,BANK0} <= 3'b000;
          MWRITE50_n          <= 1'b1;
          state_r             <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ram_seq.sv
// Directed, table-driven bench for mem_ram_seq: access timelines, reset,
// back-to-back, refresh arbitration and refresh overrun (second small-interval instance).
module tb_mem_ram_seq;

  logic        sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic        sys_rst_n, MREQ, MWR;
  logic [21:0] MADDR;
  logic        MACK, MERR, BUSY, RAS, CAS, BANK0, BANK1, BANK2, MWRITE50_n, REF_LATE;
  logic [9:0]  AA_9_0;

  logic        ov_rst_n, ov_req, ov_wr;
  logic [21:0] ov_addr;
  logic        ov_mack, ov_merr, ov_busy, ov_ras, ov_cas, ov_b0, ov_b1, ov_b2, ov_mw_n, ov_late;
  logic [9:0]  ov_aa;

  mem_ram_seq dut (
    .sysclk(sysclk), .sys_rst_n(sys_rst_n), .MREQ(MREQ), .MWR(MWR), .MADDR(MADDR),
    .MACK(MACK), .MERR(MERR), .BUSY(BUSY), .AA_9_0(AA_9_0), .RAS(RAS), .CAS(CAS),
    .BANK0(BANK0), .BANK1(BANK1), .BANK2(BANK2), .MWRITE50_n(MWRITE50_n), .REF_LATE(REF_LATE)
  );

  mem_ram_seq #(.T_CAS(30), .REF_INTERVAL(16)) dut_ov (
    .sysclk(sysclk), .sys_rst_n(ov_rst_n), .MREQ(ov_req), .MWR(ov_wr), .MADDR(ov_addr),
    .MACK(ov_mack), .MERR(ov_merr), .BUSY(ov_busy), .AA_9_0(ov_aa), .RAS(ov_ras), .CAS(ov_cas),
    .BANK0(ov_b0), .BANK1(ov_b1), .BANK2(ov_b2), .MWRITE50_n(ov_mw_n), .REF_LATE(ov_late)
  );

  typedef logic [18:0] obs_t;  // {BUSY,MACK,MERR,RAS,CAS,BANK2,BANK1,BANK0,MWRITE50_n,AA}

  typedef struct {
    logic [21:0] maddr;
    logic        mwr;
    logic [1:0]  bank;
    logic [9:0]  row;
    logic [9:0]  col;
  } vec_t;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int oc   = 0;
  logic [9:0] aa_prev;
  obs_t obs;

  assign obs = {BUSY, MACK, MERR, RAS, CAS, BANK2, BANK1, BANK0, MWRITE50_n, AA_9_0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    cyc++;
    oc++;
    @(negedge sysclk);
  endtask

  // Expected outputs t cycles after the accepting edge, default timing.
  function automatic obs_t exp_acc(input int t, input logic [1:0] b, input logic [9:0] row,
                                   input logic [9:0] col, input logic wr, input logic [9:0] aap);
    logic [2:0] bk;
    obs_t e;
    bk = (b == 2'd0) ? 3'b001 : (b == 2'd1) ? 3'b010 : 3'b100;
    if (b == 2'd3) begin
      if (t == 1) e = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, aap};
      else        e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, aap};
    end else begin
      case (t)
        1:       e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, bk, 1'b1, row};
        2, 3:    e = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, bk, 1'b1, row};
        4:       e = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, bk, ~wr, col};
        5:       e = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, bk, ~wr, col};
        6:       e = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, bk, ~wr, col};
        7, 8:    e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, col};
        default: e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, col};
      endcase
    end
    return e;
  endfunction

  vec_t vecs [5];

  initial begin
    vecs[0] = '{{2'd1, 10'h0D1, 10'h156}, 1'b0, 2'd1, 10'h0D1, 10'h156};
    vecs[1] = '{{2'd2, 10'h3FF, 10'h000}, 1'b1, 2'd2, 10'h3FF, 10'h000};
    vecs[2] = '{{2'd0, 10'h000, 10'h3FF}, 1'b0, 2'd0, 10'h000, 10'h3FF};
    vecs[3] = '{{2'd3, 10'h2AA, 10'h155}, 1'b0, 2'd3, 10'h2AA, 10'h155};
    vecs[4] = '{{2'd1, 10'h155, 10'h2AA}, 1'b1, 2'd1, 10'h155, 10'h2AA};

    sys_rst_n = 1'b0; MREQ = 1'b0; MWR = 1'b0; MADDR = 22'd0;
    ov_rst_n  = 1'b0; ov_req = 1'b0; ov_wr = 1'b0; ov_addr = 22'd0;
    repeat (3) @(negedge sysclk);
    chk("reset_outputs", 32'(obs), 32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 10'h000}));
    chk("reset_ref_late", 32'(REF_LATE), 32'd0);
    sys_rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_no_strobes", 32'(obs), 32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 10'h000}));
    end

    // Asynchronous reset in the middle of CAS_W.
    MREQ = 1'b1; MWR = 1'b0; MADDR = {2'd1, 10'h0D1, 10'h156};
    tick();
    MREQ = 1'b0;
    for (int t = 1; t <= 5; t++) tick();
    chk("pre_reset_cas_w", 32'(obs), 32'(exp_acc(5, 2'd1, 10'h0D1, 10'h156, 1'b0, 10'h000)));
    #1 sys_rst_n = 1'b0;
    #1 chk("async_reset_outputs", 32'(obs), 32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 10'h000}));
    @(negedge sysclk);
    sys_rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_reset_idle", 32'(obs), 32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 10'h000}));
    end
    aa_prev = 10'h000;

    // Table of single accesses; MADDR is scrambled after acceptance.
    for (int v = 0; v < 5; v++) begin
      MREQ = 1'b1; MWR = vecs[v].mwr; MADDR = vecs[v].maddr;
      tick();
      MREQ = 1'b0; MADDR = ~vecs[v].maddr; MWR = ~vecs[v].mwr;
      for (int t = 1; t <= ((vecs[v].bank == 2'd3) ? 2 : 9); t++) begin
        tick();
        chk($sformatf("vec%0d_t%0d", v, t), 32'(obs),
            32'(exp_acc(t, vecs[v].bank, vecs[v].row, vecs[v].col, vecs[v].mwr, aa_prev)));
      end
      if (vecs[v].bank != 2'd3) aa_prev = vecs[v].col;
    end

    // Back-to-back: write bank 2 then read bank 0 with MREQ held.
    MREQ = 1'b1; MWR = 1'b1; MADDR = {2'd2, 10'h123, 10'h321};
    tick();
    for (int t = 1; t <= 9; t++) begin
      tick();
      chk($sformatf("b2b_wr_t%0d", t), 32'(obs), 32'(exp_acc(t, 2'd2, 10'h123, 10'h321, 1'b1, aa_prev)));
      if (t == 6) begin
        MWR = 1'b0; MADDR = {2'd0, 10'h045, 10'h2F0};
      end
    end
    MREQ = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      tick();
      chk($sformatf("b2b_rd_t%0d", t), 32'(obs), 32'(exp_acc(t, 2'd0, 10'h045, 10'h2F0, 1'b0, 10'h321)));
    end
    aa_prev = 10'h2F0;

    // Refresh expiry at edge 1000; request rises right after it.
    while (cyc < 1000) tick();
    MREQ = 1'b1; MWR = 1'b0; MADDR = {2'd2, 10'h0AB, 10'h0CD};
    tick();
    chk("ref_idle_1001", 32'(obs), 32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, aa_prev}));
    tick();
    chk("ref_rrow", 32'(obs), 32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 1'b1, aa_prev}));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ref_rref", 32'(obs), 32'({1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 1'b1, aa_prev}));
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("ref_pre", 32'(obs), 32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, aa_prev}));
    end
    tick();
    chk("ref_idle_gap", 32'(obs), 32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, aa_prev}));
    MREQ = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      tick();
      chk($sformatf("after_ref_t%0d", t), 32'(obs), 32'(exp_acc(t, 2'd2, 10'h0AB, 10'h0CD, 1'b0, aa_prev)));
    end
    chk("ref_late_clear", 32'(REF_LATE), 32'd0);

    // Overrun: long CAS window spans two expiries of a 16-cycle interval.
    ov_rst_n = 1'b1; ov_req = 1'b1; ov_wr = 1'b0; ov_addr = {2'd0, 10'h011, 10'h022};
    oc = 0;
    while (oc < 31) tick();
    chk("ov_late_before", 32'(ov_late), 32'd0);
    tick();
    chk("ov_late_set", 32'(ov_late), 32'd1);
    repeat (100) tick();
    chk("ov_late_sticky", 32'(ov_late), 32'd1);
    #1 ov_rst_n = 1'b0;
    #1 chk("ov_late_reset", 32'(ov_late), 32'd0);
    ov_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
